// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
// The transmitter and the receiver both use these definitions.
//   tx_state_t  : transmitter frame state (IDLE, START, DATA, STOP)
//   DATA_WIDTH  : payload bits per frame (8)
//   FRAME_WIDTH : start + data + stop bits per frame (10)
package uart_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int FRAME_WIDTH = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_transmitter_baud_counter.sv
// baud_counter
// Bit-period timer. It counts 0..MAX-1 and then wraps to zero. The receiver
// also uses this module.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   clear : synchronous restart of the period, e.g. at the start of a frame
//   wrap  : high during the last cycle of each period (count == MAX-1)
module baud_counter #(
    parameter int MAX   = 10,
    parameter int WIDTH = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

    logic [WIDTH-1:0] count;

    // The count restarts on reset, on an explicit clear and on its own
    // wrap, so one period is always exactly MAX cycles.
    always_ff @(posedge clk) begin
        if (rst || clear || wrap) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign wrap = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter
// Serializes one byte per ready/valid handshake onto an 8N1 UART line.
// The line carries a start bit (0), eight data bits LSB first and a stop bit (1).
//   clk           : system clock, rising edge
//   rst           : synchronous active-high reset; abandons any frame in flight
//   data_in       : byte to send, sampled only on the accepting edge
//   data_in_valid : producer has a byte on data_in
//   data_in_ready : transmitter is idle and accepts a byte this cycle
//   serial_out    : UART line, idle high, always driven from a register
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic                  serial_out
);

    localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
    localparam int CLOCK_COUNTER_WIDTH = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

    // The counter cannot make a bit period shorter than two cycles.
    if (SYMBOL_EDGE_TIME < 2) begin : g_bad_baud
        $error("uart_transmitter: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end

    tx_state_t              state;
    logic [FRAME_WIDTH-1:0] frame;
    logic [2:0]             bit_idx;
    logic                   accept;
    logic                   bit_wrap;

    assign data_in_ready = (state == IDLE);
    assign accept        = data_in_valid && data_in_ready;

    // Accepting a byte restarts the bit period, so the start bit is held
    // for a full T cycles no matter where the idle counter happened to be.
    baud_counter #(
        .MAX   (SYMBOL_EDGE_TIME),
        .WIDTH (CLOCK_COUNTER_WIDTH)
    ) u_baud_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .wrap  (bit_wrap)
    );

    // Frame sequencer. The frame register shifts right at every bit boundary.
    // serial_out is loaded with the bit that becomes frame[0] after the
    // shift, which is frame[1] before the shift. The line therefore comes
    // straight from a flop. The stop bit is the MSB of the frame, so after
    // data[7] the next bit out is the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frame      <= '0;
            bit_idx    <= '0;
            serial_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    if (accept) begin
                        frame      <= {1'b1, data_in, 1'b0};
                        bit_idx    <= '0;
                        serial_out <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_wrap) begin
                        frame      <= frame >> 1;
                        serial_out <= frame[1];
                        bit_idx    <= '0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (bit_wrap) begin
                        frame      <= frame >> 1;
                        serial_out <= frame[1];
                        bit_idx    <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_wrap) begin
                        serial_out <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    serial_out <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
// Self-checking bench for uart_transmitter with T = 10 cycles per bit.
// A reference model holds the exact line waveform that each accepted byte
// must produce, one entry per clock cycle. The model takes a byte whenever
// its queue is empty and valid is high. Every cycle the bench compares the
// DUT's serial_out and data_in_ready with the model.
module tb_uart_transmitter;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int T          = CLOCK_FREQ / BAUD_RATE;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;

    int  compareCount;
    int  mismatchCount;
    bit  checkEnable;
    bit  lineQ[$];
    bit  modelReady;

    uart_transmitter #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model. On an accept, it queues the whole 8N1 frame with each
    // bit repeated T times. The front of the queue is the value the line
    // must show until the next edge. An empty queue means an idle line,
    // which is high and ready.
    always @(posedge clk) begin
        if (rst) begin
            lineQ.delete();
        end else begin
            modelReady = (lineQ.size() == 0);
            if (!modelReady) begin
                void'(lineQ.pop_front());
            end
            if (modelReady && data_in_valid) begin
                for (int k = 0; k < 10; k++) begin
                    for (int c = 0; c < T; c++) begin
                        if (k == 0)      lineQ.push_back(1'b0);
                        else if (k == 9) lineQ.push_back(1'b1);
                        else             lineQ.push_back(data_in[k-1]);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Compare the DUT with the model on every falling edge.
    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("line", int'(serial_out), (lineQ.size() != 0) ? int'(lineQ[0]) : 1);
            checkOutput("ready", int'(data_in_ready), (lineQ.size() == 0) ? 1 : 0);
        end
    end

    // Present a byte and hold valid until the model accepts it. Return on
    // the falling edge after the accepting edge. After the accept, valid
    // can stay high and data_in can be changed to newData.
    task automatic applyStimulus(input logic [7:0] b, input bit keepValid,
                                 input bit changeData, input logic [7:0] newData);
        int budget;
        @(negedge clk);
        data_in       = b;
        data_in_valid = 1'b1;
        budget        = 0;
        while (lineQ.size() != 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 2000) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL acceptWait: transmitter never became ready for 0x%02h", b);
        end
        @(negedge clk);
        if (!keepValid) data_in_valid = 1'b0;
        if (changeData) data_in = newData;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drainLine();
        int budget;
        budget = 0;
        while (lineQ.size() != 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 2000) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL drain: model line never went idle");
        end
    endtask

    initial begin
        int readyLow;
        compareCount  = 0;
        mismatchCount = 0;
        checkEnable   = 1'b0;
        rst           = 1'b1;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        @(posedge clk);
        checkEnable = 1'b1;
        @(negedge clk);
        checkOutput("resetLine", int'(serial_out), 1);
        checkOutput("resetReady", int'(data_in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] idle for 50 cycles");
        idleCycles(50);

        $display("[TB] single frame 0x55, ready low duration");
        applyStimulus(8'h55, 1'b0, 1'b0, 8'h00);
        readyLow = 0;
        while (data_in_ready == 1'b0 && readyLow < 300) begin
            readyLow++;
            @(negedge clk);
        end
        checkOutput("readyLowCycles", readyLow, 10 * T);
        idleCycles(5);

        $display("[TB] back-to-back 0xA3 / 0x0F with valid held");
        applyStimulus(8'hA3, 1'b1, 1'b1, 8'h0F);
        applyStimulus(8'h0F, 1'b0, 1'b0, 8'h00);
        drainLine();
        idleCycles(3);

        $display("[TB] data change after accept of 0x12");
        applyStimulus(8'h12, 1'b0, 1'b1, 8'hFF);
        drainLine();
        idleCycles(3);

        $display("[TB] reset during 0x00 frame");
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        idleCycles(44);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midResetLine", int'(serial_out), 1);
        checkOutput("midResetReady", int'(data_in_ready), 1);
        applyStimulus(8'h81, 1'b0, 1'b0, 8'h00);
        drainLine();
        idleCycles(2);

        $display("[TB] random bytes");
        for (int i = 0; i < 150; i++) begin
            applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                data_in_valid = 1'b0;
                idleCycles($urandom_range(0, 15));
            end
        end
        data_in_valid = 1'b0;
        drainLine();
        idleCycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
